// File: rtl/mem_access_arbiter.sv
// Memory access sequencer shared by the fetch and load/store paths.
// Runs the MOV/MOC handshake towards ram256x8, arbitrates round-robin
// when both requesters collide, and aborts strobes whose MOC never comes.
//
// state   | meaning
// --------+----------------------------------------------------------
// IDLE    | waiting for a request; grants only while mem_moc is low
// SETUP   | mem_* lines settled, mem_mov still low for one cycle
// STROBE  | mem_mov high, counting cycles until MOC or timeout
// DONE    | owner's done pulse, back to IDLE
// ERR     | owner's err pulse, back to IDLE
module mem_access_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 15
) (
    input  logic              CLK,
    input  logic              CLR,
    input  logic              f_req,
    input  logic [ADDR_W-1:0] f_addr,
    output logic              f_done,
    output logic              f_err,
    input  logic              d_req,
    input  logic              d_rw,
    input  logic [1:0]        d_type,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_done,
    output logic              d_err,
    output logic [DATA_W-1:0] rdata,
    output logic              busy,
    output logic              mem_mov,
    output logic              mem_rw,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic [1:0]        mem_type,
    input  logic              mem_moc,
    input  logic [DATA_W-1:0] mem_rdata
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_STROBE,
        S_DONE,
        S_ERR
    } state_t;

    // owner / last_gnt encoding: 1 = fetch, 0 = data
    localparam logic       OWN_FETCH = 1'b1;
    localparam logic       OWN_DATA  = 1'b0;
    localparam logic [7:0] TMO       = 8'(TIMEOUT);
    localparam logic [1:0] TYPE_WORD = 2'b10;

    state_t              state_q, state_d;
    logic                owner_q, owner_d;
    logic                last_gnt_q, last_gnt_d;
    logic [7:0]          cnt_q, cnt_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    logic                mem_rw_q, mem_rw_d;
    logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
    logic [1:0]          mem_type_q, mem_type_d;
    logic                grant_f;

    // Next-state, arbitration, handshake and timeout logic.
    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        last_gnt_d  = last_gnt_q;
        cnt_d       = cnt_q;
        rdata_d     = rdata_q;
        mem_rw_d    = mem_rw_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_type_d  = mem_type_q;
        grant_f     = 1'b0;

        case (state_q)
            S_IDLE: begin
                // A still-high MOC from the previous access blocks a new grant.
                if (!mem_moc && (f_req || d_req)) begin
                    grant_f    = f_req && (!d_req || (last_gnt_q == OWN_DATA));
                    owner_d    = grant_f ? OWN_FETCH : OWN_DATA;
                    last_gnt_d = owner_d;
                    cnt_d      = 8'd0;
                    state_d    = S_SETUP;
                    if (grant_f) begin
                        mem_addr_d = f_addr;
                        mem_rw_d   = 1'b1;
                        mem_type_d = TYPE_WORD;
                    end else begin
                        mem_addr_d  = d_addr;
                        mem_rw_d    = d_rw;
                        mem_wdata_d = d_wdata;
                        mem_type_d  = (d_type == 2'b11) ? TYPE_WORD : d_type;
                    end
                end
            end
            S_SETUP: begin
                state_d = S_STROBE;
            end
            S_STROBE: begin
                if (mem_moc) begin
                    if (mem_rw_q) begin
                        rdata_d = mem_rdata;
                    end
                    state_d = S_DONE;
                end else if (cnt_q >= TMO) begin
                    state_d = S_ERR;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            S_DONE:  state_d = S_IDLE;
            S_ERR:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge CLK) begin
        if (CLR) begin
            state_q     <= S_IDLE;
            owner_q     <= OWN_DATA;
            last_gnt_q  <= OWN_DATA;
            cnt_q       <= 8'd0;
            rdata_q     <= '0;
            mem_rw_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_type_q  <= 2'b00;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            last_gnt_q  <= last_gnt_d;
            cnt_q       <= cnt_d;
            rdata_q     <= rdata_d;
            mem_rw_q    <= mem_rw_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_type_q  <= mem_type_d;
        end
    end

    // Strobe and pulses are pure state decodes, so they follow the state flops exactly.
    always_comb begin
        busy    = (state_q != S_IDLE);
        mem_mov = (state_q == S_STROBE);
        f_done  = (state_q == S_DONE) && (owner_q == OWN_FETCH);
        d_done  = (state_q == S_DONE) && (owner_q == OWN_DATA);
        f_err   = (state_q == S_ERR)  && (owner_q == OWN_FETCH);
        d_err   = (state_q == S_ERR)  && (owner_q == OWN_DATA);
    end

    assign rdata     = rdata_q;
    assign mem_rw    = mem_rw_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign mem_type  = mem_type_q;

endmodule

// File: tb/tb_mem_access_arbiter.sv
// Directed bench for mem_access_arbiter with a behavioural byte RAM and a
// scoreboard of expected completion pulses and read data.
module tb_mem_access_arbiter;

    logic        CLK = 1'b0;
    logic        CLR;
    logic        f_req, d_req, d_rw;
    logic [31:0] f_addr, d_addr, d_wdata;
    logic [1:0]  d_type;
    logic        f_done, f_err, d_done, d_err, busy;
    logic [31:0] rdata, mem_addr, mem_wdata, mem_rdata;
    logic        mem_mov, mem_rw, mem_moc;
    logic [1:0]  mem_type;

    logic        moc_r = 1'b0;
    logic        moc_force = 1'b0;
    logic        moc_tie_low = 1'b0;
    logic [7:0]  ram [256];

    typedef struct packed {
        logic [3:0]  pulses;   // {f_done, f_err, d_done, d_err}
        logic [31:0] rdata;
    } exp_t;
    exp_t sb[$];

    int tests = 0;
    int fails = 0;

    always #5 CLK = ~CLK;

    assign mem_moc = moc_force | moc_r;

    mem_access_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(15)) dut (
        .CLK(CLK), .CLR(CLR),
        .f_req(f_req), .f_addr(f_addr), .f_done(f_done), .f_err(f_err),
        .d_req(d_req), .d_rw(d_rw), .d_type(d_type), .d_addr(d_addr),
        .d_wdata(d_wdata), .d_done(d_done), .d_err(d_err),
        .rdata(rdata), .busy(busy),
        .mem_mov(mem_mov), .mem_rw(mem_rw), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_type(mem_type),
        .mem_moc(mem_moc), .mem_rdata(mem_rdata)
    );

    // Behavioural ram256x8: answers MOC on the first falling edge that sees MOV.
    always @(negedge CLK) begin
        logic [7:0] a;
        a = mem_addr[7:0];
        if (!mem_mov) begin
            moc_r = 1'b0;
        end else if (!moc_tie_low && !moc_r) begin
            if (mem_rw) begin
                case (mem_type)
                    2'b00:   mem_rdata = {24'h0, ram[a]};
                    2'b01:   mem_rdata = {16'h0, ram[8'(a+1)], ram[a]};
                    default: mem_rdata = {ram[8'(a+3)], ram[8'(a+2)], ram[8'(a+1)], ram[a]};
                endcase
            end else begin
                mem_rdata = 32'hBAD0BAD0;
                ram[a] = mem_wdata[7:0];
                if (mem_type != 2'b00) ram[8'(a+1)] = mem_wdata[15:8];
                if (mem_type[1]) begin
                    ram[8'(a+2)] = mem_wdata[23:16];
                    ram[8'(a+3)] = mem_wdata[31:24];
                end
            end
            moc_r = 1'b1;
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Waits for the next completion pulse and checks it against the scoreboard head.
    task automatic wait_resp(input int bound, output int cyc, output int mcyc);
        exp_t       e;
        logic [3:0] p;
        bit         got;
        bit         seen;
        got = 0; seen = 0; cyc = 0; mcyc = 0;
        while (!got && cyc < bound) begin
            @(negedge CLK);
            cyc++;
            if (seen) mcyc++;
            else if (mem_mov) seen = 1;
            p = {f_done, f_err, d_done, d_err};
            if (p != 4'b0) begin
                got = 1;
                chk("sb_nonempty", 64'(sb.size() != 0), 64'd1);
                if (sb.size() != 0) begin
                    e = sb.pop_front();
                    chk("pulses", 64'(p), 64'(e.pulses));
                    chk("rdata", 64'(rdata), 64'(e.rdata));
                end
            end
        end
        chk("resp_seen", 64'(got), 64'd1);
    endtask

    initial begin
        int cyc, mcyc, prev;
        logic [3:0] any;
        CLR = 1'b1; f_req = 0; d_req = 0; d_rw = 1; d_type = 2'b10;
        f_addr = '0; d_addr = '0; d_wdata = '0; mem_rdata = '0;
        foreach (ram[i]) ram[i] = 8'(i);
        ram[8'h40] = 8'hEF; ram[8'h41] = 8'hBE; ram[8'h42] = 8'hAD; ram[8'h43] = 8'hDE;
        ram[8'h20] = 8'h11; ram[8'h21] = 8'h22;

        repeat (3) @(negedge CLK);
        chk("reset_ctrl", 64'({busy, mem_mov, mem_rw, mem_type, f_done, f_err, d_done, d_err}), 64'd0);
        chk("reset_rdata", 64'(rdata), 64'd0);
        chk("reset_addr", 64'({mem_addr, mem_wdata}), 64'd0);
        CLR = 1'b0;

        // Fetch alone
        @(negedge CLK);
        f_addr = 32'h40;
        sb.push_back('{4'b1000, 32'hDEADBEEF});
        f_req = 1;
        wait_resp(20, cyc, mcyc);
        f_req = 0;
        chk("fetch_latency", 64'(cyc), 64'd3);
        chk("fetch_type_rw", 64'({mem_type, mem_rw}), 64'({2'b10, 1'b1}));
        chk("fetch_addr", 64'(mem_addr), 64'h40);
        repeat (2) @(negedge CLK);

        // Byte store 0xA5 at 0x20
        d_rw = 0; d_type = 2'b00; d_addr = 32'h20; d_wdata = 32'h5A5A5AA5;
        sb.push_back('{4'b0010, 32'hDEADBEEF});
        d_req = 1;
        wait_resp(20, cyc, mcyc);
        d_req = 0;
        chk("store_byte", 64'(ram[8'h20]), 64'hA5);
        chk("store_neighbour", 64'(ram[8'h21]), 64'h22);
        @(negedge CLK);

        // Byte load back
        d_rw = 1;
        sb.push_back('{4'b0010, 32'h000000A5});
        d_req = 1;
        wait_resp(20, cyc, mcyc);
        d_req = 0;
        chk("load_type", 64'(mem_type), 64'd0);
        @(negedge CLK);

        // Type 11 behaves as a word read
        d_type = 2'b11; d_addr = 32'h40;
        sb.push_back('{4'b0010, 32'hDEADBEEF});
        d_req = 1;
        wait_resp(20, cyc, mcyc);
        d_req = 0;
        chk("type11_word", 64'(mem_type), 64'd2);

        // Conflict after reset: fetch, data, fetch, data
        CLR = 1;
        repeat (2) @(negedge CLK);
        CLR = 0;
        chk("clr_rdata", 64'(rdata), 64'd0);
        f_addr = 32'h40; d_addr = 32'h20; d_rw = 1; d_type = 2'b00;
        sb.push_back('{4'b1000, 32'hDEADBEEF});
        sb.push_back('{4'b0010, 32'h000000A5});
        sb.push_back('{4'b1000, 32'hDEADBEEF});
        sb.push_back('{4'b0010, 32'h000000A5});
        f_req = 1; d_req = 1;
        for (int i = 0; i < 4; i++) begin
            wait_resp(20, cyc, mcyc);
            if (i > 0) chk($sformatf("b2b_spacing_%0d", i), 64'(cyc), 64'd4);
        end
        f_req = 0; d_req = 0;
        @(negedge CLK);

        // MOC never arrives
        moc_tie_low = 1;
        d_addr = 32'h40; d_type = 2'b10; d_rw = 1;
        sb.push_back('{4'b0001, 32'h000000A5});
        d_req = 1;
        wait_resp(40, cyc, mcyc);
        d_req = 0;
        chk("timeout_cycles", 64'(mcyc), 64'd16);
        @(negedge CLK);
        chk("timeout_mov_low", 64'({mem_mov, d_done, d_err}), 64'd0);
        moc_tie_low = 0;
        @(negedge CLK);

        // CLR during STROBE
        moc_tie_low = 1;
        f_addr = 32'h40;
        f_req = 1;
        cyc = 0;
        while (!mem_mov && cyc < 10) begin
            @(negedge CLK);
            cyc++;
        end
        chk("strobe_reached", 64'(mem_mov), 64'd1);
        repeat (2) @(negedge CLK);
        CLR = 1; f_req = 0;
        @(negedge CLK);
        chk("clr_mid_ctrl", 64'({mem_mov, busy, f_done, f_err, d_done, d_err}), 64'd0);
        CLR = 0;
        any = 4'b0;
        repeat (4) begin
            @(negedge CLK);
            any = any | {f_done, f_err, d_done, d_err};
        end
        chk("clr_no_pulse", 64'(any), 64'd0);
        moc_tie_low = 0;
        sb.push_back('{4'b1000, 32'hDEADBEEF});
        f_req = 1;
        wait_resp(20, cyc, mcyc);
        f_req = 0;
        chk("post_clr_latency", 64'(cyc), 64'd3);
        repeat (2) @(negedge CLK);

        // MOC stuck high in IDLE holds off the grant
        moc_force = 1;
        f_req = 1;
        repeat (4) @(negedge CLK);
        chk("moc_high_no_grant", 64'({busy, mem_mov}), 64'd0);
        moc_force = 0;
        sb.push_back('{4'b1000, 32'hDEADBEEF});
        wait_resp(20, cyc, mcyc);
        f_req = 0;
        chk("moc_release_latency", 64'(cyc), 64'd3);
        prev = sb.size();
        chk("sb_drained", 64'(prev), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
